// File: rtl/bus_pkg.sv
// Shared definitions for the two-master strobe/ack bus arbiter and its helpers.
package bus_pkg;

    localparam int ADR_W = 32;
    localparam int DAT_W = 32;
    localparam int SEL_W = 4;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_BUSY    = 2'b01;
    localparam logic [1:0] ST_RELEASE = 2'b10;

    localparam logic [DAT_W-1:0] TIMEOUT_RDATA = 32'h0000_0000;

    typedef struct packed {
        logic             we;
        logic [ADR_W-1:0] adr;
        logic [DAT_W-1:0] dat;
        logic [SEL_W-1:0] sel;
    } bus_req_t;

    // Master index (0/1) to one-hot grant vector.
    function automatic logic [1:0] grant_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/bus_timer.sv
// Loadable up-counter with clear, enable and terminal-count flag used as a bus watchdog.
module bus_timer #(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_r;
    logic             tc_s;

    // Counter register: clear wins over load, load wins over increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= '0;
        end else if (clr) begin
            cnt_r <= '0;
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Terminal count; a zero TIMEOUT_CYCLES disables the flag entirely.
    always_comb begin
        tc_s = 1'b0;
        if (TIMEOUT_CYCLES != 0) begin
            tc_s = (cnt_r == TC_VAL);
        end else begin
            tc_s = 1'b0;
        end
    end

    assign tc = tc_s;

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin two-master / one-slave arbiter for the strobe/ack memory bus,
// one transfer per grant, with a watchdog that force-completes hung transfers.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256,
    parameter int CNT_W          = 9
) (
    input  logic             clk,
    input  logic             rst_i,
    input  logic             m0_stb_i,
    input  logic             m0_we_i,
    input  logic [ADR_W-1:0] m0_adr_i,
    input  logic [DAT_W-1:0] m0_dat_i,
    input  logic [SEL_W-1:0] m0_sel_i,
    output logic [DAT_W-1:0] m0_dat_o,
    output logic             m0_ack_o,
    input  logic             m1_stb_i,
    input  logic             m1_we_i,
    input  logic [ADR_W-1:0] m1_adr_i,
    input  logic [DAT_W-1:0] m1_dat_i,
    input  logic [SEL_W-1:0] m1_sel_i,
    output logic [DAT_W-1:0] m1_dat_o,
    output logic             m1_ack_o,
    output logic             s_stb_o,
    output logic             s_we_o,
    output logic [ADR_W-1:0] s_adr_o,
    output logic [DAT_W-1:0] s_dat_o,
    output logic [SEL_W-1:0] s_sel_o,
    input  logic [DAT_W-1:0] s_dat_i,
    input  logic             s_ack_i,
    output logic [1:0]       grant_o,
    output logic             err_o
);

    logic [1:0] state_r;
    logic [1:0] grant_r;
    logic       last_owner_r;

    logic [1:0] state_nxt_s;
    logic [1:0] grant_nxt_s;
    logic       last_owner_nxt_s;

    logic       busy_s;
    logic       tc_s;
    logic       timeout_s;
    logic       done_s;
    logic       other_stb_s;
    bus_req_t   sel_req_s;

    assign busy_s    = (state_r == ST_BUSY);
    assign timeout_s = busy_s & tc_s & ~s_ack_i;
    assign done_s    = busy_s & (s_ack_i | timeout_s);

    // The master that did not own the last transfer; the only one eligible in RELEASE.
    assign other_stb_s = last_owner_r ? m0_stb_i : m1_stb_i;

    bus_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .CNT_W         (CNT_W)
    ) u_timer (
        .clk     (clk),
        .rst     (rst_i),
        .clr     (~busy_s),
        .en      (busy_s & ~s_ack_i),
        .load    (1'b0),
        .load_val({CNT_W{1'b0}}),
        .tc      (tc_s)
    );

    // Next-state, next-grant and round-robin pointer selection.
    always_comb begin
        state_nxt_s      = state_r;
        grant_nxt_s      = grant_r;
        last_owner_nxt_s = last_owner_r;
        case (state_r)
            ST_IDLE: begin
                if (m0_stb_i && m1_stb_i) begin
                    grant_nxt_s = grant_onehot(~last_owner_r);
                    state_nxt_s = ST_BUSY;
                end else if (m0_stb_i) begin
                    grant_nxt_s = 2'b01;
                    state_nxt_s = ST_BUSY;
                end else if (m1_stb_i) begin
                    grant_nxt_s = 2'b10;
                    state_nxt_s = ST_BUSY;
                end else begin
                    grant_nxt_s = 2'b00;
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_BUSY: begin
                if (done_s) begin
                    last_owner_nxt_s = grant_r[1];
                    grant_nxt_s      = 2'b00;
                    state_nxt_s      = ST_RELEASE;
                end else begin
                    grant_nxt_s = grant_r;
                    state_nxt_s = ST_BUSY;
                end
            end
            ST_RELEASE: begin
                // The finishing master may still hold a stale strobe here, so it is ignored.
                if (other_stb_s) begin
                    grant_nxt_s = grant_onehot(~last_owner_r);
                    state_nxt_s = ST_BUSY;
                end else begin
                    grant_nxt_s = 2'b00;
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                grant_nxt_s = 2'b00;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_r      <= ST_IDLE;
            grant_r      <= 2'b00;
            last_owner_r <= 1'b1;
        end else begin
            state_r      <= state_nxt_s;
            grant_r      <= grant_nxt_s;
            last_owner_r <= last_owner_nxt_s;
        end
    end

    // Request mux toward the slave, steered by the registered grant.
    always_comb begin
        sel_req_s = '0;
        if (grant_r[1]) begin
            sel_req_s = '{we: m1_we_i, adr: m1_adr_i, dat: m1_dat_i, sel: m1_sel_i};
        end else begin
            sel_req_s = '{we: m0_we_i, adr: m0_adr_i, dat: m0_dat_i, sel: m0_sel_i};
        end
    end

    assign s_stb_o = busy_s;
    assign s_we_o  = sel_req_s.we;
    assign s_adr_o = sel_req_s.adr;
    assign s_dat_o = sel_req_s.dat;
    assign s_sel_o = sel_req_s.sel;

    assign m0_ack_o = done_s & grant_r[0];
    assign m1_ack_o = done_s & grant_r[1];
    assign m0_dat_o = (timeout_s & grant_r[0]) ? TIMEOUT_RDATA : s_dat_i;
    assign m1_dat_o = (timeout_s & grant_r[1]) ? TIMEOUT_RDATA : s_dat_i;

    assign grant_o = grant_r;
    assign err_o   = timeout_s;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed scoreboard bench for bus_arbiter: expected slave requests and master
// completions are queued by the stimulus and consumed by an independent monitor.
module tb_bus_arbiter;

    localparam int TO = 4;
    localparam int CW = 3;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        m0_stb_i, m0_we_i, m1_stb_i, m1_we_i;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic [31:0] m0_dat_o, m1_dat_o;
    logic        m0_ack_o, m1_ack_o;
    logic        s_stb_o, s_we_o;
    logic [31:0] s_adr_o, s_dat_o, s_dat_i;
    logic [3:0]  s_sel_o;
    logic        s_ack_i;
    logic [1:0]  grant_o;
    logic        err_o;

    bus_arbiter #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst_i(rst_i),
        .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
        .m0_sel_i(m0_sel_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
        .m1_sel_i(m1_sel_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o), .s_dat_o(s_dat_o),
        .s_sel_o(s_sel_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
        .grant_o(grant_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  grant;
        logic        we;
        logic [31:0] adr;
        logic [31:0] dat;
        logic [3:0]  sel;
    } req_t;

    typedef struct {
        int          m;
        logic [31:0] dat;
        logic        err;
    } ack_t;

    req_t        req_q[$];
    ack_t        ack_q[$];
    logic [31:0] slv_q[$];

    int   checks    = 0;
    int   errors    = 0;
    int   ack_at    = 0;
    int   stb_rises = 0;
    int   r0        = 0;
    logic mon_prev  = 1'b0;
    req_t mon_e;
    ack_t mon_a;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_m(input int m, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        if (m == 0) begin
            m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat; m0_sel_i = sel;
        end else begin
            m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = sel;
        end
    endtask

    task automatic wait_ack(input int m);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = (m == 0) ? m0_ack_o : m1_ack_o;
        end
        check("wait_ack", {31'd0, got}, 32'd1);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
    endtask

    // Slave model: acks on the ack_at-th BUSY cycle with the next queued read word.
    initial begin
        int busy_cnt;
        busy_cnt = 0;
        s_ack_i  = 1'b0;
        s_dat_i  = 32'hDEAD_BEEF;
        forever begin
            @(posedge clk);
            #1;
            s_ack_i = 1'b0;
            s_dat_i = 32'hDEAD_BEEF;
            if (s_stb_o) begin
                busy_cnt++;
                if (busy_cnt == ack_at) begin
                    s_ack_i = 1'b1;
                    if (slv_q.size() > 0) s_dat_i = slv_q.pop_front();
                end
            end else begin
                busy_cnt = 0;
            end
        end
    end

    // Monitor: checks slave-side requests every BUSY cycle and each master completion.
    initial begin
        forever begin
            @(negedge clk);
            if (s_stb_o && !mon_prev) stb_rises++;
            mon_prev = s_stb_o;
            if (s_stb_o) begin
                if (req_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_req: adr %h grant %b", s_adr_o, grant_o);
                end else begin
                    mon_e = req_q[0];
                    check("req_grant", {30'd0, grant_o}, {30'd0, mon_e.grant});
                    check("req_we",    {31'd0, s_we_o},  {31'd0, mon_e.we});
                    check("req_adr",   s_adr_o, mon_e.adr);
                    check("req_dat",   s_dat_o, mon_e.dat);
                    check("req_sel",   {28'd0, s_sel_o}, {28'd0, mon_e.sel});
                end
            end
            if (m0_ack_o || m1_ack_o || err_o) begin
                if (ack_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack: m0 %b m1 %b err %b", m0_ack_o, m1_ack_o, err_o);
                end else begin
                    mon_a = ack_q.pop_front();
                    check("ack_m0",  {31'd0, m0_ack_o}, {31'd0, (mon_a.m == 0)});
                    check("ack_m1",  {31'd0, m1_ack_o}, {31'd0, (mon_a.m == 1)});
                    check("ack_dat", (mon_a.m == 0) ? m0_dat_o : m1_dat_o, mon_a.dat);
                    check("ack_err", {31'd0, err_o}, {31'd0, mon_a.err});
                end
                if (s_stb_o && req_q.size() > 0) void'(req_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b1;
        set_m(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_m(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        step();
        step();
        @(negedge clk);
        check("rst_grant", {30'd0, grant_o}, 32'd0);
        check("rst_stb",   {31'd0, s_stb_o}, 32'd0);
        check("rst_ack",   {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
        check("rst_err",   {31'd0, err_o}, 32'd0);
        step();
        rst_i = 1'b0;

        // Single master read, slave acks on the third BUSY cycle
        ack_at = 3;
        slv_q.push_back(32'hCAFE_F00D);
        req_q.push_back('{2'b01, 1'b0, 32'h100, 32'h0, 4'hF});
        ack_q.push_back('{0, 32'hCAFE_F00D, 1'b0});
        set_m(0, 1'b1, 1'b0, 32'h100, 32'h0, 4'hF);
        @(negedge clk);
        check("t1_stb_not_yet", {31'd0, s_stb_o}, 32'd0);
        step();
        @(negedge clk);
        check("t1_stb_t1", {31'd0, s_stb_o}, 32'd1);
        step();
        step();
        @(negedge clk);
        check("t1_ack_cycle", {31'd0, m0_ack_o}, 32'd1);
        check("t1_ack_data", m0_dat_o, 32'hCAFE_F00D);
        step();
        m0_stb_i = 1'b0;
        @(negedge clk);
        check("t1_release_stb", {31'd0, s_stb_o}, 32'd0);
        step();
        @(negedge clk);
        check("t1_idle_grant", {30'd0, grant_o}, 32'd0);

        // Tie after reset goes to m0, m1 follows at ack+2, next tie back to m0
        do_reset();
        ack_at = 1;
        slv_q.push_back(32'h1111_1111);
        slv_q.push_back(32'h2222_2222);
        req_q.push_back('{2'b01, 1'b0, 32'h10, 32'hA0, 4'hF});
        req_q.push_back('{2'b10, 1'b0, 32'h20, 32'hB0, 4'h3});
        ack_q.push_back('{0, 32'h1111_1111, 1'b0});
        ack_q.push_back('{1, 32'h2222_2222, 1'b0});
        set_m(0, 1'b1, 1'b0, 32'h10, 32'hA0, 4'hF);
        set_m(1, 1'b1, 1'b0, 32'h20, 32'hB0, 4'h3);
        step();
        @(negedge clk);
        check("t2_tie_m0", {30'd0, grant_o}, 32'd1);
        step();
        m0_stb_i = 1'b0;
        @(negedge clk);
        check("t2_release_gap", {31'd0, s_stb_o}, 32'd0);
        step();
        @(negedge clk);
        check("t2_m1_at_ack2", {31'd0, s_stb_o}, 32'd1);
        check("t2_m1_grant", {30'd0, grant_o}, 32'd2);
        step();
        m1_stb_i = 1'b0;
        step();
        slv_q.push_back(32'h3333_3333);
        slv_q.push_back(32'h4444_4444);
        req_q.push_back('{2'b01, 1'b0, 32'h30, 32'hC0, 4'hF});
        req_q.push_back('{2'b10, 1'b0, 32'h40, 32'hD0, 4'hC});
        ack_q.push_back('{0, 32'h3333_3333, 1'b0});
        ack_q.push_back('{1, 32'h4444_4444, 1'b0});
        set_m(0, 1'b1, 1'b0, 32'h30, 32'hC0, 4'hF);
        set_m(1, 1'b1, 1'b0, 32'h40, 32'hD0, 4'hC);
        step();
        @(negedge clk);
        check("t2_next_tie_m0", {30'd0, grant_o}, 32'd1);
        step();
        m0_stb_i = 1'b0;
        wait_ack(1);
        step();
        m1_stb_i = 1'b0;
        step();

        // Stale strobe: m0 holds stb through RELEASE, no second transfer may start
        ack_at = 2;
        r0 = stb_rises;
        slv_q.push_back(32'h5A5A_5A5A);
        req_q.push_back('{2'b01, 1'b0, 32'h400, 32'h0, 4'hF});
        ack_q.push_back('{0, 32'h5A5A_5A5A, 1'b0});
        set_m(0, 1'b1, 1'b0, 32'h400, 32'h0, 4'hF);
        wait_ack(0);
        step();
        @(negedge clk);
        check("t3_release_stb", {31'd0, s_stb_o}, 32'd0);
        step();
        m0_stb_i = 1'b0;
        @(negedge clk);
        check("t3_idle_stb", {31'd0, s_stb_o}, 32'd0);
        check("t3_idle_grant", {30'd0, grant_o}, 32'd0);
        step();
        step();
        check("t3_one_pulse", stb_rises - r0, 32'd1);

        // Write passthrough from m1
        ack_at = 2;
        slv_q.push_back(32'h0);
        req_q.push_back('{2'b10, 1'b1, 32'h203, 32'h55, 4'b1000});
        ack_q.push_back('{1, 32'h0, 1'b0});
        set_m(1, 1'b1, 1'b1, 32'h203, 32'h55, 4'b1000);
        wait_ack(1);
        step();
        m1_stb_i = 1'b0;
        step();

        // Timeout with no ack: forced completion on the fourth BUSY cycle
        ack_at = 0;
        req_q.push_back('{2'b01, 1'b0, 32'h300, 32'h0, 4'hF});
        ack_q.push_back('{0, 32'h0, 1'b1});
        set_m(0, 1'b1, 1'b0, 32'h300, 32'h0, 4'hF);
        step();
        step();
        step();
        @(negedge clk);
        check("t5_no_err_b3", {31'd0, err_o}, 32'd0);
        step();
        @(negedge clk);
        check("t5_ack_b4", {31'd0, m0_ack_o}, 32'd1);
        check("t5_err_b4", {31'd0, err_o}, 32'd1);
        check("t5_dat_zero", m0_dat_o, 32'h0);
        step();
        m0_stb_i = 1'b0;
        step();

        // Slave ack coincides with the timeout cycle: normal completion
        ack_at = 4;
        slv_q.push_back(32'h1234_5678);
        req_q.push_back('{2'b01, 1'b0, 32'h304, 32'h0, 4'hF});
        ack_q.push_back('{0, 32'h1234_5678, 1'b0});
        set_m(0, 1'b1, 1'b0, 32'h304, 32'h0, 4'hF);
        step();
        step();
        step();
        step();
        @(negedge clk);
        check("t5b_ack", {31'd0, m0_ack_o}, 32'd1);
        check("t5b_err", {31'd0, err_o}, 32'd0);
        check("t5b_dat", m0_dat_o, 32'h1234_5678);
        step();
        m0_stb_i = 1'b0;
        step();

        // Reset in the middle of an m1 transfer, then a tie must go to m0
        ack_at = 0;
        req_q.push_back('{2'b10, 1'b0, 32'h500, 32'h0, 4'hF});
        set_m(1, 1'b1, 1'b0, 32'h500, 32'h0, 4'hF);
        step();
        step();
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        m1_stb_i = 1'b0;
        @(negedge clk);
        check("t6_stb_low", {31'd0, s_stb_o}, 32'd0);
        check("t6_grant_zero", {30'd0, grant_o}, 32'd0);
        check("t6_no_ack", {31'd0, m1_ack_o}, 32'd0);
        req_q.delete();
        ack_at = 1;
        slv_q.push_back(32'h6666_6666);
        slv_q.push_back(32'h7777_7777);
        req_q.push_back('{2'b01, 1'b0, 32'h600, 32'h0, 4'hF});
        req_q.push_back('{2'b10, 1'b0, 32'h700, 32'h0, 4'hF});
        ack_q.push_back('{0, 32'h6666_6666, 1'b0});
        ack_q.push_back('{1, 32'h7777_7777, 1'b0});
        set_m(0, 1'b1, 1'b0, 32'h600, 32'h0, 4'hF);
        set_m(1, 1'b1, 1'b0, 32'h700, 32'h0, 4'hF);
        step();
        @(negedge clk);
        check("t6_tie_m0", {30'd0, grant_o}, 32'd1);
        step();
        m0_stb_i = 1'b0;
        wait_ack(1);
        step();
        m1_stb_i = 1'b0;
        step();
        step();

        check("drain_ack_q", ack_q.size(), 32'd0);
        check("drain_req_q", req_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
